// File: rtl/eth_dma_burst_scheduler_pkg.sv
// Shared definitions for the eth DMA burst scheduler.
//   state_e          FSM state encoding (IDLE, ARB, ISSUE, WAIT, UPD)
//   BURST_*          burst sizes in words selected by r_burst_len
//   BOUNDARY_WORDS_DEF  AHB 1 KB boundary expressed in 32-bit words
//   SEL_TX / SEL_RX  channel select codes, also used as context indices
package eth_dma_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT,
    ST_UPD
  } state_e;

  localparam int unsigned BURST_SINGLE = 1;
  localparam int unsigned BURST_INCR4  = 4;
  localparam int unsigned BURST_INCR8  = 8;
  localparam int unsigned BURST_INCR16 = 16;

  localparam int unsigned BOUNDARY_WORDS_DEF = 256;

  localparam logic SEL_TX = 1'b0;
  localparam logic SEL_RX = 1'b1;

  // Burst size code (0=SINGLE, 1=INCR4, 2=INCR8, 3=INCR16) to word count.
  function automatic logic [4:0] burst_words(input logic [1:0] code);
    case (code)
      2'd0:    return 5'(BURST_SINGLE);
      2'd1:    return 5'(BURST_INCR4);
      2'd2:    return 5'(BURST_INCR8);
      default: return 5'(BURST_INCR16);
    endcase
  endfunction

endpackage

// File: rtl/eth_dma_burst_scheduler_if.sv
// Burst command channel between the scheduler and the AHB master engine.
//   master modport: scheduler drives cmd_valid/cmd_write/cmd_sel/cmd_addr/
//                   cmd_beats, receives cmd_ready/cmd_done/cmd_err
//   slave modport:  engine side, directions mirrored
interface eth_dma_cmd_if #(
  parameter int ADDR_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [4:0]        cmd_beats;
  logic              cmd_done;
  logic              cmd_err;

  modport master (
    output cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_beats,
    input  cmd_ready, cmd_done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_beats,
    output cmd_ready, cmd_done, cmd_err
  );
endinterface

// File: rtl/eth_dma_wrr_pick.sv
// Combinational channel choice for the next burst.
//   act_tx_i/act_rx_i     channel contexts active
//   arb_scheme_i          1=fixed priority, 0=weighted round robin
//   txrx_priority_i       1=tx preferred, 0=rx preferred
//   priority_ratio_i      preferred channel gets ratio+1 bursts per turn
//   grant_cnt_i           preferred grants already used in this turn
//   pref_spent_i          preferred quota exhausted, other channel is owed one
//   sel_o                 chosen channel (SEL_TX/SEL_RX)
//   pref_win_o            chosen channel is the preferred one
//   quota_last_o          this grant uses the last preferred slot of the turn
module eth_dma_wrr_pick
  import eth_dma_sched_pkg::*;
(
  input  logic       act_tx_i,
  input  logic       act_rx_i,
  input  logic       arb_scheme_i,
  input  logic       txrx_priority_i,
  input  logic [2:0] priority_ratio_i,
  input  logic [2:0] grant_cnt_i,
  input  logic       pref_spent_i,
  output logic       sel_o,
  output logic       pref_win_o,
  output logic       quota_last_o
);
  logic pref;

  // NOTE: every output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    pref         = txrx_priority_i ? SEL_TX : SEL_RX;
    sel_o        = SEL_TX;
    if (act_tx_i && !act_rx_i)       sel_o = SEL_TX;
    else if (act_rx_i && !act_tx_i)  sel_o = SEL_RX;
    else if (arb_scheme_i || !pref_spent_i) sel_o = pref;
    else                             sel_o = ~pref;
    pref_win_o   = (sel_o == pref);
    // ratio+1 slots need nine counter states at ratio 7, so the final slot
    // is flagged separately instead of counting past the ratio.
    quota_last_o = pref_win_o && (grant_cnt_i == priority_ratio_i);
  end
endmodule

// File: rtl/eth_dma_burst_scheduler.sv
// Splits tx/rx DMA jobs into AHB bursts that never cross a 1 KB boundary and
// interleaves the two channels burst by burst.
//   module_clk/module_rst     clock, synchronous active-high reset
//   r_*                       burst size, WRR ratio, preferred channel, scheme
//   tx_*/rx_*                 job request/ack/done/err per channel
//   cmd                       burst command channel (eth_dma_cmd_if.master)
//   busy                      any job active or command in flight
// Optional build macro ETH_DMA_SCHED_STATS_EN adds stats_clr and saturating
// tx_burst_cnt/rx_burst_cnt/err_cnt counters.
module eth_dma_burst_scheduler
  import eth_dma_sched_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 12,
  parameter int BOUNDARY_WORDS = BOUNDARY_WORDS_DEF
) (
  input  logic              module_clk,
  input  logic              module_rst,
  input  logic [1:0]        r_burst_len,
  input  logic [2:0]        r_priority_ratio,
  input  logic              r_txrx_priority,
  input  logic              r_arb_scheme,
  input  logic              tx_req,
  input  logic              rx_req,
  input  logic [ADDR_W-1:0] tx_addr,
  input  logic [ADDR_W-1:0] rx_addr,
  input  logic [LEN_W-1:0]  tx_words,
  input  logic [LEN_W-1:0]  rx_words,
  output logic              tx_ack,
  output logic              rx_ack,
  output logic              tx_done,
  output logic              rx_done,
  output logic              tx_err,
  output logic              rx_err,
  eth_dma_cmd_if.master     cmd,
  output logic              busy
`ifdef ETH_DMA_SCHED_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       tx_burst_cnt,
  output logic [15:0]       rx_burst_cnt,
  output logic [7:0]        err_cnt
`endif
);
  state_e            state_q;
  logic [1:0]        act_q, ack_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q [2];
  logic [LEN_W-1:0]  rem_q  [2];
  logic [2:0]        grant_cnt_q;
  logic              pref_spent_q;
  logic              err_seen_q;
  logic              cmd_valid_q, cmd_write_q, cmd_sel_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [4:0]        cmd_beats_q;

  logic              pick_sel, pick_pref_win, pick_quota_last;
  logic [1:0]        req_d;
  logic [ADDR_W-1:0] job_addr_d [2];
  logic [LEN_W-1:0]  job_words_d [2];
  logic [4:0]        beats_d;
  logic              upd_fin_d;
  logic [1:0]        act_after_d;
  int unsigned       lim_burst, lim_rem, lim_bnd, lim_min;

  eth_dma_wrr_pick u_pick (
    .act_tx_i         (act_q[SEL_TX]),
    .act_rx_i         (act_q[SEL_RX]),
    .arb_scheme_i     (r_arb_scheme),
    .txrx_priority_i  (r_txrx_priority),
    .priority_ratio_i (r_priority_ratio),
    .grant_cnt_i      (grant_cnt_q),
    .pref_spent_i     (pref_spent_q),
    .sel_o            (pick_sel),
    .pref_win_o       (pick_pref_win),
    .quota_last_o     (pick_quota_last)
  );

  always_comb begin
    req_d          = {rx_req, tx_req};
    job_addr_d[0]  = tx_addr;
    job_addr_d[1]  = rx_addr;
    job_words_d[0] = tx_words;
    job_words_d[1] = rx_words;
    // beats = min(burst size, remaining words, words left before the 1 KB line)
    lim_burst = 32'(burst_words(r_burst_len));
    lim_rem   = 32'(rem_q[pick_sel]);
    lim_bnd   = 32'(BOUNDARY_WORDS) - 32'(addr_q[pick_sel][9:2]);
    lim_min   = lim_burst;
    if (lim_rem < lim_min) lim_min = lim_rem;
    if (lim_bnd < lim_min) lim_min = lim_bnd;
    beats_d   = lim_min[4:0];
    upd_fin_d = err_seen_q || (rem_q[cmd_sel_q] == LEN_W'(cmd_beats_q));
    act_after_d = act_q;
    if (upd_fin_d) act_after_d[cmd_sel_q] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the values from before this clock edge.
  always_ff @(posedge module_clk) begin
    if (module_rst) begin
      state_q      <= ST_IDLE;
      act_q        <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      // NOTE: the two-entry context arrays are cleared on reset; a stale
      // address or length must never leak into a job accepted afterwards.
      for (int ch = 0; ch < 2; ch++) begin
        addr_q[ch] <= '0;
        rem_q[ch]  <= '0;
      end
      grant_cnt_q  <= '0;
      pref_spent_q <= 1'b0;
      err_seen_q   <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_sel_q    <= SEL_TX;
      cmd_addr_q   <= '0;
      cmd_beats_q  <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      err_q  <= '0;

      // Job intake; the ack_q guard stops a still-high req from re-latching
      // a zero-length job in the cycle its ack is visible.
      for (int ch = 0; ch < 2; ch++) begin
        if (!act_q[ch] && req_d[ch] && !ack_q[ch]) begin
          ack_q[ch]  <= 1'b1;
          addr_q[ch] <= job_addr_d[ch] & ~ADDR_W'(3);
          rem_q[ch]  <= job_words_d[ch];
          if (job_words_d[ch] == '0) done_q[ch] <= 1'b1;
          else                       act_q[ch]  <= 1'b1;
        end
      end

      // WRR turn bookkeeping only matters while both channels compete.
      if (!(act_q[SEL_TX] && act_q[SEL_RX])) begin
        grant_cnt_q  <= '0;
        pref_spent_q <= 1'b0;
      end else if (state_q == ST_ARB) begin
        if (!pick_pref_win) begin
          grant_cnt_q  <= '0;
          pref_spent_q <= 1'b0;
        end else if (pick_quota_last) begin
          pref_spent_q <= 1'b1;
        end else begin
          grant_cnt_q  <= grant_cnt_q + 3'd1;
        end
      end

      case (state_q)
        ST_IDLE: if (|act_q) state_q <= ST_ARB;
        ST_ARB: begin
          cmd_sel_q   <= pick_sel;
          cmd_write_q <= (pick_sel == SEL_RX);
          cmd_addr_q  <= addr_q[pick_sel];
          cmd_beats_q <= beats_d;
          cmd_valid_q <= 1'b1;
          state_q     <= ST_ISSUE;
        end
        ST_ISSUE: if (cmd.cmd_ready) begin
          cmd_valid_q <= 1'b0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: if (cmd.cmd_done) begin
          err_seen_q <= cmd.cmd_err;
          state_q    <= ST_UPD;
        end
        ST_UPD: begin
          if (err_seen_q) begin
            err_q[cmd_sel_q] <= 1'b1;
          end else begin
            addr_q[cmd_sel_q] <= addr_q[cmd_sel_q] + ADDR_W'({cmd_beats_q, 2'b00});
            rem_q[cmd_sel_q]  <= rem_q[cmd_sel_q] - LEN_W'(cmd_beats_q);
          end
          if (upd_fin_d) begin
            act_q[cmd_sel_q]  <= 1'b0;
            done_q[cmd_sel_q] <= 1'b1;
          end
          err_seen_q <= 1'b0;
          state_q    <= (|act_after_d) ? ST_ARB : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_ack        = ack_q[SEL_TX];
  assign rx_ack        = ack_q[SEL_RX];
  assign tx_done       = done_q[SEL_TX];
  assign rx_done       = done_q[SEL_RX];
  assign tx_err        = err_q[SEL_TX];
  assign rx_err        = err_q[SEL_RX];
  assign cmd.cmd_valid = cmd_valid_q;
  assign cmd.cmd_write = cmd_write_q;
  assign cmd.cmd_sel   = cmd_sel_q;
  assign cmd.cmd_addr  = cmd_addr_q;
  assign cmd.cmd_beats = cmd_beats_q;
  assign busy          = (|act_q) || (state_q != ST_IDLE);

`ifdef ETH_DMA_SCHED_STATS_EN
  logic [15:0] tx_bc_q, rx_bc_q;
  logic [7:0]  err_cnt_q;
  logic        issue_hs, err_hit;

  assign issue_hs = (state_q == ST_ISSUE) && cmd.cmd_ready;
  assign err_hit  = (state_q == ST_WAIT) && cmd.cmd_done && cmd.cmd_err;

  always_ff @(posedge module_clk) begin
    if (module_rst || stats_clr) begin
      tx_bc_q   <= '0;
      rx_bc_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      if (issue_hs && cmd_sel_q == SEL_TX && tx_bc_q != '1) tx_bc_q <= tx_bc_q + 16'd1;
      if (issue_hs && cmd_sel_q == SEL_RX && rx_bc_q != '1) rx_bc_q <= rx_bc_q + 16'd1;
      if (err_hit && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign tx_burst_cnt = tx_bc_q;
  assign rx_burst_cnt = rx_bc_q;
  assign err_cnt      = err_cnt_q;
`endif
endmodule

// File: tb/tb_eth_dma_burst_scheduler.sv
// Directed self-checking bench for eth_dma_burst_scheduler. A small engine
// process answers burst commands and logs them; the main initial block runs
// the directed steps and compares against hand-computed expectations.
module tb_eth_dma_burst_scheduler;
  logic        module_clk = 1'b0;
  logic        module_rst;
  logic [1:0]  r_burst_len;
  logic [2:0]  r_priority_ratio;
  logic        r_txrx_priority, r_arb_scheme;
  logic        tx_req, rx_req;
  logic [31:0] tx_addr, rx_addr;
  logic [11:0] tx_words, rx_words;
  logic        tx_ack, rx_ack, tx_done, rx_done, tx_err, rx_err, busy;
`ifdef ETH_DMA_SCHED_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] tx_burst_cnt, rx_burst_cnt;
  logic [7:0]  err_cnt;
`endif

  always #5 module_clk = ~module_clk;

  eth_dma_cmd_if #(.ADDR_W(32)) cmd_bus ();

  eth_dma_burst_scheduler dut (
    .module_clk       (module_clk),
    .module_rst       (module_rst),
    .r_burst_len      (r_burst_len),
    .r_priority_ratio (r_priority_ratio),
    .r_txrx_priority  (r_txrx_priority),
    .r_arb_scheme     (r_arb_scheme),
    .tx_req           (tx_req),
    .rx_req           (rx_req),
    .tx_addr          (tx_addr),
    .rx_addr          (rx_addr),
    .tx_words         (tx_words),
    .rx_words         (rx_words),
    .tx_ack           (tx_ack),
    .rx_ack           (rx_ack),
    .tx_done          (tx_done),
    .rx_done          (rx_done),
    .tx_err           (tx_err),
    .rx_err           (rx_err),
    .cmd              (cmd_bus),
    .busy             (busy)
`ifdef ETH_DMA_SCHED_STATS_EN
    ,
    .stats_clr        (stats_clr),
    .tx_burst_cnt     (tx_burst_cnt),
    .rx_burst_cnt     (rx_burst_cnt),
    .err_cnt          (err_cnt)
`endif
  );

  typedef struct {
    logic        sel;
    logic        write;
    logic [31:0] addr;
    logic [4:0]  beats;
  } burst_t;

  burst_t log_q[$];
  int     err_idx = -1;
  int     total = 0;
  int     passed = 0;

  // Monitor: pulse counts and cycle stamps.
  int   cyc = 0, tx_done_n = 0, rx_done_n = 0, tx_err_n = 0, valid_n = 0;
  int   tx_done_cyc = 0, rx_done_cyc = 0;
  logic tx_err_at_done = 1'b0, rx_err_at_done = 1'b0;
  initial forever begin
    @(negedge module_clk);
    cyc++;
    if (cmd_bus.cmd_valid) valid_n++;
    if (tx_err) tx_err_n++;
    if (tx_done) begin tx_done_n++; tx_done_cyc = cyc; tx_err_at_done = tx_err; end
    if (rx_done) begin rx_done_n++; rx_done_cyc = cyc; rx_err_at_done = rx_err; end
  end

  // Engine model: one stall cycle, handshake, one idle cycle, then done.
  initial begin
    bit inject;
    cmd_bus.cmd_ready = 1'b0;
    cmd_bus.cmd_done  = 1'b0;
    cmd_bus.cmd_err   = 1'b0;
    forever begin
      @(negedge module_clk);
      cmd_bus.cmd_ready = 1'b0;
      cmd_bus.cmd_done  = 1'b0;
      cmd_bus.cmd_err   = 1'b0;
      if (cmd_bus.cmd_valid && !module_rst) begin
        @(negedge module_clk);
        inject = (log_q.size() == err_idx);
        log_q.push_back('{cmd_bus.cmd_sel, cmd_bus.cmd_write, cmd_bus.cmd_addr, cmd_bus.cmd_beats});
        cmd_bus.cmd_ready = 1'b1;
        @(negedge module_clk);
        cmd_bus.cmd_ready = 1'b0;
        @(negedge module_clk);
        cmd_bus.cmd_done  = 1'b1;
        cmd_bus.cmd_err   = inject;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [38:0] pk(input logic s, input logic w, input logic [31:0] a,
                                     input logic [4:0] b);
    return {s, w, a, b};
  endfunction

  function automatic logic [38:0] log_at(input int i);
    if (i < log_q.size()) return pk(log_q[i].sel, log_q[i].write, log_q[i].addr, log_q[i].beats);
    return '1;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge module_clk);
  endtask

  task automatic start_jobs(input logic dt, input logic dr, input logic [31:0] ta,
                            input logic [11:0] tw, input logic [31:0] ra,
                            input logic [11:0] rw, input string tag);
    tx_req = dt; tx_addr = ta; tx_words = tw;
    rx_req = dr; rx_addr = ra; rx_words = rw;
    @(negedge module_clk);
    check({tag, "_ack"}, {tx_ack, rx_ack}, {dt, dr});
    tx_req = 1'b0;
    rx_req = 1'b0;
    @(negedge module_clk);
    check({tag, "_ack_pulse"}, {tx_ack, rx_ack}, 2'b00);
  endtask

  task automatic wait_dones(input int tx_t, input int rx_t, input int budget, input string tag);
    for (int i = 0; i < budget && !(tx_done_n >= tx_t && rx_done_n >= rx_t); i++)
      @(negedge module_clk);
    check(tag, (tx_done_n >= tx_t && rx_done_n >= rx_t), 1'b1);
  endtask

  initial begin
    int t0, r0, e0, v0, ti, ri;
    logic [19:0] exp_sel3;
    module_rst = 1'b1;
    r_burst_len = 2'd0; r_priority_ratio = 3'd0; r_txrx_priority = 1'b1; r_arb_scheme = 1'b1;
    tx_req = 1'b0; rx_req = 1'b0; tx_addr = '0; rx_addr = '0; tx_words = '0; rx_words = '0;
    wait_cycles(3);
    check("reset_outputs", {busy, cmd_bus.cmd_valid, tx_ack, rx_ack, tx_done, rx_done, tx_err, rx_err}, 8'h00);
    module_rst = 1'b0;
    wait_cycles(2);
    check("idle_after_reset", {busy, cmd_bus.cmd_valid}, 2'b00);

    // 1: tx 0x100 / 20 words, INCR8
    r_burst_len = 2'd2;
    t0 = tx_done_n; r0 = rx_done_n;
    start_jobs(1'b1, 1'b0, 32'h100, 12'd20, 32'h0, 12'd0, "t1");
    wait_dones(t0 + 1, r0, 300, "t1_done_timeout");
    wait_cycles(4);
    check("t1_count", log_q.size(), 3);
    check("t1_b0", log_at(0), pk(1'b0, 1'b0, 32'h100, 5'd8));
    check("t1_b1", log_at(1), pk(1'b0, 1'b0, 32'h120, 5'd8));
    check("t1_b2", log_at(2), pk(1'b0, 1'b0, 32'h140, 5'd4));
    check("t1_no_err", tx_err_at_done, 1'b0);
    check("t1_busy", busy, 1'b0);
    log_q.delete();

    // 2: rx 0x3F8 / 10 words, INCR16, split at the 1 KB line
    r_burst_len = 2'd3;
    t0 = tx_done_n; r0 = rx_done_n;
    start_jobs(1'b0, 1'b1, 32'h0, 12'd0, 32'h3F8, 12'd10, "t2");
    wait_dones(t0, r0 + 1, 300, "t2_done_timeout");
    wait_cycles(4);
    check("t2_count", log_q.size(), 2);
    check("t2_b0", log_at(0), pk(1'b1, 1'b1, 32'h3F8, 5'd2));
    check("t2_b1", log_at(1), pk(1'b1, 1'b1, 32'h400, 5'd8));
    log_q.delete();

    // 3: WRR, tx preferred, ratio 2, INCR4, 40 words each
    r_burst_len = 2'd1; r_arb_scheme = 1'b0; r_txrx_priority = 1'b1; r_priority_ratio = 3'd2;
    exp_sel3 = 20'b1111_1110_1000_1000_1000;
    t0 = tx_done_n; r0 = rx_done_n;
    start_jobs(1'b1, 1'b1, 32'h0, 12'd40, 32'h1000, 12'd40, "t3");
    wait_dones(t0 + 1, r0 + 1, 800, "t3_done_timeout");
    wait_cycles(4);
    check("t3_count", log_q.size(), 20);
    ti = 0; ri = 0;
    for (int i = 0; i < 20; i++) begin
      if (exp_sel3[i]) begin
        check($sformatf("t3_b%0d", i), log_at(i), pk(1'b1, 1'b1, 32'h1000 + 32'(16 * ri), 5'd4));
        ri++;
      end else begin
        check($sformatf("t3_b%0d", i), log_at(i), pk(1'b0, 1'b0, 32'(16 * ti), 5'd4));
        ti++;
      end
    end
    check("t3_tx_first", tx_done_cyc < rx_done_cyc, 1'b1);
    log_q.delete();

    // 4: fixed priority, rx preferred
    r_arb_scheme = 1'b1; r_txrx_priority = 1'b0;
    t0 = tx_done_n; r0 = rx_done_n;
    start_jobs(1'b1, 1'b1, 32'h500, 12'd8, 32'h600, 12'd8, "t4");
    wait_dones(t0 + 1, r0 + 1, 300, "t4_done_timeout");
    wait_cycles(4);
    check("t4_count", log_q.size(), 4);
    check("t4_b0", log_at(0), pk(1'b1, 1'b1, 32'h600, 5'd4));
    check("t4_b1", log_at(1), pk(1'b1, 1'b1, 32'h610, 5'd4));
    check("t4_b2", log_at(2), pk(1'b0, 1'b0, 32'h500, 5'd4));
    check("t4_b3", log_at(3), pk(1'b0, 1'b0, 32'h510, 5'd4));
    check("t4_rx_first", rx_done_cyc < tx_done_cyc, 1'b1);
    log_q.delete();

    // 5: bus error on tx's second burst while rx runs (WRR alternation)
    r_arb_scheme = 1'b0; r_txrx_priority = 1'b1; r_priority_ratio = 3'd0;
    err_idx = 2;
    t0 = tx_done_n; r0 = rx_done_n; e0 = tx_err_n;
    start_jobs(1'b1, 1'b1, 32'h2000, 12'd16, 32'h3000, 12'd12, "t5");
    wait_dones(t0 + 1, r0 + 1, 400, "t5_done_timeout");
    wait_cycles(4);
    err_idx = -1;
    check("t5_tx_err_with_done", tx_err_at_done, 1'b1);
    check("t5_tx_err_pulses", tx_err_n - e0, 1);
    check("t5_rx_clean", rx_err_at_done, 1'b0);
    check("t5_count", log_q.size(), 5);
    check("t5_b0", log_at(0), pk(1'b0, 1'b0, 32'h2000, 5'd4));
    check("t5_b1", log_at(1), pk(1'b1, 1'b1, 32'h3000, 5'd4));
    check("t5_b2", log_at(2), pk(1'b0, 1'b0, 32'h2010, 5'd4));
    check("t5_b3", log_at(3), pk(1'b1, 1'b1, 32'h3010, 5'd4));
    check("t5_b4", log_at(4), pk(1'b1, 1'b1, 32'h3020, 5'd4));
    check("t5_busy", busy, 1'b0);
    log_q.delete();

    // 6: zero-length job: ack and done together, no command
    v0 = valid_n;
    tx_req = 1'b1; tx_addr = 32'h40; tx_words = 12'd0;
    @(negedge module_clk);
    check("t6_ack_done", {tx_ack, tx_done, tx_err}, 3'b110);
    tx_req = 1'b0;
    @(negedge module_clk);
    check("t6_pulse", {tx_ack, tx_done}, 2'b00);
    wait_cycles(6);
    check("t6_no_valid", valid_n - v0, 0);
    check("t6_busy", busy, 1'b0);

    // 7: reset while waiting for cmd_done
    r_burst_len = 2'd2;
    tx_req = 1'b1; tx_addr = 32'h800; tx_words = 12'd8;
    for (int i = 0; i < 20 && !cmd_bus.cmd_valid; i++) @(negedge module_clk);
    tx_req = 1'b0;
    check("t7_issue_seen", cmd_bus.cmd_valid, 1'b1);
    wait_cycles(2);
    check("t7_in_wait", {busy, cmd_bus.cmd_valid}, 2'b10);
    module_rst = 1'b1;
    @(negedge module_clk);
    check("t7_reset_outputs", {busy, cmd_bus.cmd_valid, tx_ack, rx_ack, tx_done, rx_done, tx_err, rx_err}, 8'h00);
    module_rst = 1'b0;
    wait_cycles(6);
    check("t7_stays_idle", {busy, cmd_bus.cmd_valid, tx_done}, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
